// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array job sequencer.
package systolic_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_NUM_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  typedef logic [DEF_NUM_BITS-1:0]       elem_t;
  typedef logic [DEF_N*DEF_NUM_BITS-1:0] row_t;
  typedef logic [DEF_N*DEF_N*(2*DEF_NUM_BITS+$clog2(DEF_N)+4)-1:0] mat_t;

  // Cycles needed after the last activation row for the skewed wavefront to clear the array.
  function automatic int drain_len(input int n, input int pe_lat);
    return 2*(n-1) + pe_lat;
  endfunction

endpackage

// File: rtl/systolic_seq_skew_line.sv
// Enabled shift register delaying one west lane by DEPTH advance steps.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) sr_d[k] = sr_q[k];
    if (en_i) begin
      sr_d[0] = d_i;
      for (int k = 1; k < DEPTH; k++) sr_d[k] = sr_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= '{default: '0};
    else      sr_q <= sr_d;
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for an NxN systolic array: loads weight rows, skews activation
// rows onto the west edge, drains the wavefront and snapshots the result matrix.
//
// state  | meaning
// IDLE   | waiting for start_i; clear_o pulses with start unless accumulating
// LOAD   | accepting N weight rows onto north_o
// STREAM | accepting N activation rows into the skew lines
// DRAIN  | feeding zeros until the last partial sums settle
// DONE   | c_o snapshot taken, done_o high for one cycle
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int ACC_BITS = 2*NUM_BITS + $clog2(N) + 4,
  parameter int PE_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       acc_mode_i,
  input  logic                       w_valid_i,
  output logic                       w_ready_o,
  input  logic [N*NUM_BITS-1:0]      w_row_i,
  input  logic                       a_valid_i,
  output logic                       a_ready_o,
  input  logic [N*NUM_BITS-1:0]      a_row_i,
  output logic [N*NUM_BITS-1:0]      north_o,
  output logic [N*NUM_BITS-1:0]      west_o,
  output logic                       load_o,
  output logic                       en_o,
  output logic                       clear_o,
  input  logic [N*N*ACC_BITS-1:0]    c_i,
  output logic [N*N*ACC_BITS-1:0]    c_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int D  = drain_len(N, PE_LAT);
  localparam int CW = $clog2(N + D + 1);
  localparam int RW = N*NUM_BITS;
  localparam int CB = N*N*ACC_BITS;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_ready_q, w_ready_d, a_ready_q, a_ready_d;
  logic          load_q, load_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [RW-1:0] north_q, north_d, west_q, west_d, skew_in;
  logic [CB-1:0] c_q, c_d;
  logic          w_acc, a_acc, sh_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_acc   = (state_q == LOAD) && w_valid_i;
    a_acc   = (state_q == STREAM) && a_valid_i;
    sh_en   = a_acc || (state_q == DRAIN);
    case (state_q)
      IDLE: if (start_i) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if (w_acc) begin
        if (cnt_q == CW'(N-1)) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      STREAM: if (a_acc) begin
        if (cnt_q == CW'(N-1)) begin
          state_d = DRAIN;
          cnt_d   = CW'(D-1);
        end else cnt_d = cnt_q + CW'(1);
      end
      DRAIN: if (cnt_q == '0) state_d = DONE;
             else cnt_d = cnt_q - CW'(1);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    w_ready_d = (state_d == LOAD);
    a_ready_d = (state_d == STREAM);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    load_d    = w_acc;
    north_d   = w_acc ? w_row_i : '0;
    en_d      = sh_en;
    c_d       = (state_d == DONE) ? c_i : c_q;
  end

  // Zeros enter the skew lines during DRAIN so the tails flush clean for the next job.
  assign skew_in = a_acc ? a_row_i : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [NUM_BITS-1:0] lane_out;
    if (i == 0) begin : g_direct
      assign lane_out = skew_in[0 +: NUM_BITS];
    end else begin : g_skew
      skew_line #(.DEPTH(i), .WIDTH(NUM_BITS)) u_skew (
        .clk  (clk),
        .rst  (rst),
        .en_i (sh_en),
        .d_i  (skew_in[i*NUM_BITS +: NUM_BITS]),
        .q_o  (lane_out)
      );
    end
    assign west_d[i*NUM_BITS +: NUM_BITS] = sh_en ? lane_out : west_q[i*NUM_BITS +: NUM_BITS];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      load_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      north_q   <= '0;
      west_q    <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      load_q    <= load_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      north_q   <= north_d;
      west_q    <= west_d;
      c_q       <= c_d;
    end
  end

  assign clear_o   = (state_q == IDLE) && start_i && !acc_mode_i;
  assign w_ready_o = w_ready_q;
  assign a_ready_o = a_ready_q;
  assign load_o    = load_q;
  assign en_o      = en_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign north_o   = north_q;
  assign west_o    = west_q;
  assign c_o       = c_q;

endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
- Job sequencer in front of the NxN systolic array: accepts weight rows and activation rows over valid/ready streams.
- Loads weights into the array, then skews activations onto the west edge.
- Counts the drain, snapshots the array's C matrix and pulses done.
- Adds accumulate mode (K-tiling across jobs) and stall support.

Parameters:
- N, 4, array dimension (lanes, rows per job); N>=1
- NUM_BITS, 8, operand width
- ACC_BITS, 2*NUM_BITS+$clog2(N)+4, result width; the +4 allows 16 accumulated tiles
- PE_LAT, 1, array PE register latency in cycles

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  job start request; sampled in IDLE only
- acc_mode_i  in  1  1 = keep array accumulators (no clear_o); latched at start
- w_valid_i  in  1  weight row valid
- w_ready_o  out  1  weight row accepted when w_valid_i & w_ready_o
- w_row_i  in  N x NUM_BITS  weight row
- a_valid_i  in  1  activation row valid
- a_ready_o  out  1  activation handshake ready
- a_row_i  in  N x NUM_BITS  activation row, element i -> west lane i
- north_o  out  N x NUM_BITS  to array north_i
- west_o  out  N x NUM_BITS  to array west_i
- load_o  out  1  north_o carries a weight row this cycle
- en_o  out  1  array advance enable
- clear_o  out  1  one-cycle array accumulator clear
- c_i  in  N x N x ACC_BITS  array C_o
- c_o  out  N x N x ACC_BITS  registered result snapshot
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; c_o cleared; skew registers 0; counters 0.
- States: IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start_i=1: latch acc_mode_i, row counter=0, go LOAD next cycle.
  - clear_o=1 in that same cycle iff acc_mode_i=0.
- LOAD:
  - w_ready_o=1.
  - Accepted beat: north_o=w_row_i (registered, 1 cycle latency), load_o=1, row counter++.
  - No beat: north_o=0, load_o=0.
  - After N accepted beats: counter=0, go STREAM.
- STREAM:
  - a_ready_o=1.
  - Accepted beat: element i enters skew line i (depth i; lane 0 depth 0, registered once), en_o=1, counter++.
  - a_valid_i=0: skew lines and en_o frozen (en_o=0, west_o holds). Stall is exact; results are unaffected.
  - After N beats: go DRAIN.
- DRAIN:
  - en_o=1 every cycle; zeros fed into skew inputs.
  - Lasts D = 2*(N-1)+PE_LAT cycles, not stallable. Then DONE.
- DONE: c_o <= c_i; done_o=1 for one cycle; then IDLE. c_o holds until the next DONE or reset.
- w_ready_o=0 outside LOAD; a_ready_o=0 outside STREAM. Valid inputs in other states are ignored and not consumed.
- start_i while busy_o=1 is ignored.
- Job length with no stalls, start to done_o: 1+N+N+D+1 cycles (N=4, PE_LAT=1: 17).
- N=1: skew lines are empty, D=PE_LAT.
- Reset mid-job aborts it: no done_o, array state is not guaranteed; the next job must use acc_mode_i=0.
- No saturation: ACC_BITS wraps modulo 2^ACC_BITS.

Decomposition:
- Package systolic_pkg: state enum (IDLE, LOAD, STREAM, DRAIN, DONE), default N and NUM_BITS, row/matrix typedefs, drain-length function.
- Sub-module skew_line (parameter DEPTH, WIDTH, enable): a shift register, instantiated per lane with DEPTH=i.

Test Plan:
- Identity: A=B=I4, acc_mode=0, no stalls -> done_o at cycle 17 after start; c_o = I4; clear_o pulsed once.
- All ones: A=B=ones(4) -> c_o all 4.
- Accumulate: all-ones job (acc_mode=0), then a second all-ones job (acc_mode=1) -> c_o all 8; no clear_o on the second job.
- Stalls: drop a_valid_i for 3 cycles mid-STREAM and w_valid_i for 2 cycles mid-LOAD -> c_o identical to the no-stall run; done_o 5 cycles later; en_o low during the stalls.
- Protocol: start_i pulsed during DRAIN ignored; a_valid_i asserted in LOAD not consumed (a_ready_o=0).
- Reset: assert rst low mid-STREAM -> all outputs 0 immediately, busy_o=0, no done_o. Then an identity job with acc_mode=0 -> c_o = I4. Repeat identity with N=2 -> done_o at 1+2+2+3+1=9 cycles.
